display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed driver for a three-digit common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter: it consumes the hundreds/tens/ones digit codes, including code 10 (dash) and code 11 (blank), and latches them tear-free at frame boundaries. It scans one digit at a time with an anti-ghosting gap, and can optionally blink the whole display.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ 2)
- GAP, 1000, cycles at the start of each slot with all anodes off (1 ≤ GAP < REFRESH_DIV)
- BLINK_FRAMES, 167, frames per blink half-period (≥ 1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  one-cycle strobe: capture hundreds/tens/ones
- hundreds  in  4  digit code for the leftmost digit
- tens  in  4  digit code for the middle digit
- ones  in  4  digit code for the rightmost digit
- blink_en  in  1  enables blinking
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  3  anodes, active-low; an[2]=hundreds, an[1]=tens, an[0]=ones
- ready  out  1  high when no load is pending
- frame  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- **Scan FSM:** states DIG_H → DIG_T → DIG_O → DIG_H, with a slot counter cnt running 0..REFRESH_DIV-1.
  - The state advances when cnt == REFRESH_DIV-1; cnt then wraps to 0.
- **Frame boundary (FB):** the cycle with state == DIG_O and cnt == REFRESH_DIV-1.
- **Input registers:** pend_h/t/o hold the pending digits; disp_h/t/o hold the displayed digits.
- **Load handling:**
  - A load in a non-FB cycle writes the pend registers and sets pending.
  - A further load while pending overwrites the pend registers; the last load wins.
  - At FB with pending set, disp ← pend and pending clears.
  - A load coincident with FB writes disp directly from the inputs. pending stays clear.
- ready = !pending.
- **Decode (seg7_decode):**
  - 0–9: standard glyphs.
  - 10: dash, segment g only.
  - 11–15: blank, all segments off.
- **Slot output:**
  - While cnt < GAP: an = 3'b111 and seg = 7'h7F.
  - Otherwise, an = 0 only on the active digit, and seg = decode of that digit's disp register.
- **Blink:**
  - A frame counter increments at each FB.
  - At count BLINK_FRAMES-1 it wraps and toggles the vis flag.
  - When blink_en && !vis, seg = 7'h7F while an keeps scanning.
  - While blink_en = 0, the counter holds at 0 and vis = 1.
- **Reset values:**
  - Outputs: seg = 7'h7F, an = 3'b111, ready = 1, frame = 0.
  - Internal: disp and pend = 4'hB, state = DIG_H, cnt = 0, frame counter = 0, vis = 1, pending = 0.

## Timing
- seg, an and frame are registered. Each reflects the state, cnt and disp values of the previous cycle (1-cycle latency).
- ready is registered from pending and falls on the cycle after an accepted non-FB load.
- Frame period = 3·REFRESH_DIV cycles.
- **Load-to-display latency:** new digits appear on seg at the first non-gap output of DIG_H in the frame after the next FB.
- Reset asserted mid-frame forces all reset values immediately (asynchronously). The scan restarts at DIG_H cnt 0 on the first clock edge after deassertion.
- Input codes are sampled only on the load cycle. The inputs are don't-care otherwise.
- Counter widths are $clog2 of their terminal values. No arithmetic overflow is possible.

## Structure
- **Package display_pkg:**
  - CODE_DASH = 4'hA and CODE_BLANK = 4'hB.
  - SEG_OFF = 7'h7F and SEG_DASH = 7'h3F.
  - scan_state_t enum {DIG_H, DIG_T, DIG_O}.
- **Sub-module seg7_decode:** combinational, 4-bit code → 7-bit active-low glyph. It is instantiated once, on the muxed active digit.

## Test plan
Unless noted, parameters are REFRESH_DIV = 8, GAP = 2, BLINK_FRAMES = 2.

1. **Reset:** assert reset → seg = 7'h7F, an = 3'b111, ready = 1. After release, an cycles 011, 101, 110 (6 cycles each, preceded by 2 off cycles) while seg stays 7'h7F.
2. **Mid-frame load:** load 1/2/3 at cnt 3 of DIG_T → ready = 0 next cycle, then ready = 1 after FB. The following frame shows seg = 7'h79 / 7'h24 / 7'h30 on an = 011 / 101 / 110.
3. **Dash and blank codes:** load 10/10/10 → seg = 7'h3F on all three digits. Load 11/13/15 → seg = 7'h7F on all three digits.
4. **Last load wins:** load 4, then load 7 within the same frame → only 7 is ever displayed. ready is 0 from the first load until FB.
5. **Load at FB / reset mid-load:**
   - Load 5/5/5 at the FB cycle → ready stays 1, and the next frame shows 5.
   - Reset during a pending load → displays blank and ready = 1.
6. **Blink:** blink_en = 1 with digits 8/8/8 → 2 frames with seg = 7'h00 during active slots, then 2 frames with seg = 7'h7F while an still scans. frame pulses once every 24 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the three-digit seven-segment scanner.
// Digit codes 10 and 11 come from the upstream binary-to-BCD converter as dash and blank.
package display_pkg;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {
    DIG_H,
    DIG_T,
    DIG_O
  } scan_state_t;

  // One frame's worth of digit codes
  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } digits_t;

endpackage

// File: rtl/display_scan_if.sv
// Host-side bundle for display_scan.
//   load/hundreds/tens/ones : one-cycle capture strobe and digit codes
//   blink_en                : whole-display blink enable
//   seg/an                  : active-low segment and anode drives
//   ready/frame             : no-load-pending flag, end-of-frame pulse
interface display_scan_if;
  logic       load;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blink_en;
  logic [6:0] seg;
  logic [2:0] an;
  logic       ready;
  logic       frame;

  modport master (
    output load, hundreds, tens, ones, blink_en,
    input  seg, an, ready, frame
  );

  modport slave (
    input  load, hundreds, tens, ones, blink_en,
    output seg, an, ready, frame
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low glyph decoder, bit order {g,f,e,d,c,b,a}.
//   code    : 4-bit digit code (0-9 digits, 10 dash, 11-15 blank)
//   glyph_c : 7-bit active-low segment pattern
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_OFF;
    case (code)
      4'd0:      glyph_c = 7'h40;
      4'd1:      glyph_c = 7'h79;
      4'd2:      glyph_c = 7'h24;
      4'd3:      glyph_c = 7'h30;
      4'd4:      glyph_c = 7'h19;
      4'd5:      glyph_c = 7'h12;
      4'd6:      glyph_c = 7'h02;
      4'd7:      glyph_c = 7'h78;
      4'd8:      glyph_c = 7'h00;
      4'd9:      glyph_c = 7'h10;
      CODE_DASH: glyph_c = SEG_DASH;
      default:   glyph_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed three-digit common-anode display driver with tear-free
// frame-boundary digit latching, anti-ghosting gap and optional blink.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : display_scan_if slave (load/digits/blink_en in; seg/an/ready/frame out)
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GAP          = 1000,
  parameter int unsigned BLINK_FRAMES = 167
) (
  input  logic           clk,
  input  logic           reset,
  display_scan_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             fb;

  digits_t          pend;
  digits_t          disp;
  digits_t          din;
  logic             pending;
  logic             pending_nxt;

  logic [FC_W-1:0]  fcnt;
  logic             vis;

  logic [3:0]       code_sel;
  logic [2:0]       an_active;
  logic [6:0]       glyph;
  logic [6:0]       seg_nxt;
  logic [2:0]       an_nxt;

  logic [6:0]       seg_q;
  logic [2:0]       an_q;
  logic             ready_q;
  logic             frame_q;

  assign slot_end = (cnt == CNT_LAST);
  assign fb       = slot_end && (state == DIG_O);
  assign din      = '{h: bus.hundreds, t: bus.tens, o: bus.ones};

  // Scan state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIG_H;
    else       state <= state_nxt;
  end

  // Scan next state: advance one digit per slot
  always_comb begin
    state_nxt = state;
    if (slot_end) begin
      case (state)
        DIG_H:   state_nxt = DIG_T;
        DIG_T:   state_nxt = DIG_O;
        DIG_O:   state_nxt = DIG_H;
        default: state_nxt = DIG_H;
      endcase
    end
  end

  // Slot counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (slot_end) cnt <= '0;
    else               cnt <= cnt + CNT_W'(1);
  end

  // A load at the frame boundary bypasses pend, so pending never survives FB
  always_comb begin
    pending_nxt = pending;
    if (fb)            pending_nxt = 1'b0;
    else if (bus.load) pending_nxt = 1'b1;
  end

  // Pending/displayed digit registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '{h: CODE_BLANK, t: CODE_BLANK, o: CODE_BLANK};
      disp    <= '{h: CODE_BLANK, t: CODE_BLANK, o: CODE_BLANK};
      pending <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (fb && bus.load)    disp <= din;
      else if (fb && pending) disp <= pend;
      else if (bus.load)     pend <= din;
    end
  end

  // Blink frame counter and visibility flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
      vis  <= 1'b1;
    end else if (!bus.blink_en) begin
      fcnt <= '0;
      vis  <= 1'b1;
    end else if (fb) begin
      if (fcnt == FC_LAST) begin
        fcnt <= '0;
        vis  <= !vis;
      end else begin
        fcnt <= fcnt + FC_W'(1);
      end
    end
  end

  // Output decode: select the active digit, blank during the gap or blink-off
  always_comb begin
    code_sel  = disp.h;
    an_active = 3'b011;
    an_nxt    = 3'b111;
    seg_nxt   = SEG_OFF;
    case (state)
      DIG_H:   begin code_sel = disp.h; an_active = 3'b011; end
      DIG_T:   begin code_sel = disp.t; an_active = 3'b101; end
      DIG_O:   begin code_sel = disp.o; an_active = 3'b110; end
      default: begin code_sel = disp.h; an_active = 3'b011; end
    endcase
    if (cnt >= GAP_END) begin
      an_nxt  = an_active;
      seg_nxt = (bus.blink_en && !vis) ? SEG_OFF : glyph;
    end
  end

  seg7_decode u_decode (
    .code    (code_sel),
    .glyph_c (glyph)
  );

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= SEG_OFF;
      an_q    <= 3'b111;
      ready_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_nxt;
      an_q    <= an_nxt;
      ready_q <= !pending_nxt;
      frame_q <= fb;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.ready = ready_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: a frame-position reference model pushes the
// expected {seg,an,ready,frame} per cycle into a scoreboard queue, popped after each edge.
module tb_display_scan;
  import display_pkg::*;

  localparam int unsigned RD = 8;
  localparam int unsigned GP = 2;
  localparam int unsigned BF = 2;
  localparam int FR = 3 * RD;

  logic clk = 1'b0;
  logic reset;

  display_scan_if bus ();

  display_scan #(
    .REFRESH_DIV  (RD),
    .GAP          (GP),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_pos;
  logic [3:0] m_disp [3];
  logic [3:0] m_pend [3];
  bit         m_pending;
  bit         m_vis;
  int         m_fc;
  int         obs_pos;
  int         cyc = 0;
  int         last_frame = -1;
  logic [11:0] sb [$];
  logic [2:0] an_exp [3] = '{3'b011, 3'b101, 3'b110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      4'd10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_pending = 1'b0;
    m_vis = 1'b1;
    m_fc = 0;
    for (int i = 0; i < 3; i++) begin
      m_disp[i] = 4'hB;
      m_pend[i] = 4'hB;
    end
  endtask

  function automatic logic [11:0] model_out();
    int d;
    int c;
    bit fb;
    bit pn;
    logic [6:0] s;
    logic [2:0] a;
    if (reset) return {7'h7F, 3'b111, 1'b1, 1'b0};
    d  = m_pos / RD;
    c  = m_pos % RD;
    fb = (m_pos == FR - 1);
    if (c < GP) begin
      a = 3'b111;
      s = 7'h7F;
    end else begin
      a = an_exp[d];
      s = (bus.blink_en && !m_vis) ? 7'h7F : glyph(m_disp[d]);
    end
    pn = fb ? 1'b0 : (bus.load ? 1'b1 : m_pending);
    return {s, a, !pn, fb};
  endfunction

  task automatic model_step();
    bit fb;
    if (reset) begin
      model_reset();
      return;
    end
    fb = (m_pos == FR - 1);
    if (fb && bus.load) begin
      m_disp[0] = bus.hundreds; m_disp[1] = bus.tens; m_disp[2] = bus.ones;
      m_pending = 1'b0;
    end else if (fb && m_pending) begin
      m_disp = m_pend;
      m_pending = 1'b0;
    end else if (bus.load) begin
      m_pend[0] = bus.hundreds; m_pend[1] = bus.tens; m_pend[2] = bus.ones;
      m_pending = 1'b1;
    end
    if (!bus.blink_en) begin
      m_fc = 0;
      m_vis = 1'b1;
    end else if (fb) begin
      if (m_fc == BF - 1) begin
        m_fc = 0;
        m_vis = !m_vis;
      end else begin
        m_fc++;
      end
    end
    m_pos = (m_pos + 1) % FR;
  endtask

  // One clock: predict, advance model, then compare the registered outputs
  task automatic tick();
    logic [11:0] got;
    logic [11:0] e;
    sb.push_back(model_out());
    obs_pos = reset ? -1 : m_pos;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    got = {bus.seg, bus.an, bus.ready, bus.frame};
    e = sb.pop_front();
    check("cycle", 32'(got), 32'(e));
    if (reset) last_frame = -1;
    else if (bus.frame) begin
      if (last_frame >= 0) check("frame_period", 32'(cyc - last_frame), 32'(FR));
      last_frame = cyc;
    end
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < FR && m_pos != p; i++) tick();
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.load = 1'b1;
    bus.hundreds = h;
    bus.tens = t;
    bus.ones = o;
    tick();
    bus.load = 1'b0;
    bus.hundreds = 4'($urandom);
    bus.tens = 4'($urandom);
    bus.ones = 4'($urandom);
  endtask

  // Walk one full frame, checking gap and first active output of every slot
  task automatic check_frame(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2);
    logic [6:0] g [3];
    g = '{g0, g1, g2};
    run_until(0);
    for (int i = 0; i < FR; i++) begin
      tick();
      if (obs_pos >= 0 && obs_pos % RD == 0)
        check("gap_an", 32'(bus.an), 32'(3'b111));
      if (obs_pos >= 0 && obs_pos % RD == GP) begin
        check("slot_an", 32'(bus.an), 32'(an_exp[obs_pos / RD]));
        check("slot_seg", 32'(bus.seg), 32'(g[obs_pos / RD]));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 1'b0;
    bus.hundreds = 4'd0;
    bus.tens = 4'd0;
    bus.ones = 4'd0;
    bus.blink_en = 1'b0;
    model_reset();

    // Reset values, then an empty scan
    repeat (2) tick();
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_an", 32'(bus.an), 32'(3'b111));
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_frame", 32'(bus.frame), 32'd0);
    reset = 1'b0;
    check_frame(7'h7F, 7'h7F, 7'h7F);

    // Mid-frame load at cnt 3 of DIG_T
    run_until(RD + 3);
    do_load(4'd1, 4'd2, 4'd3);
    check("mid_ready_low", 32'(bus.ready), 32'd0);
    run_until(0);
    check("mid_ready_fb", 32'(bus.ready), 32'd1);
    check_frame(7'h79, 7'h24, 7'h30);

    // Dash and blank codes
    run_until(5);
    do_load(4'd10, 4'd10, 4'd10);
    run_until(0);
    check_frame(7'h3F, 7'h3F, 7'h3F);
    run_until(5);
    do_load(4'd11, 4'd13, 4'd15);
    run_until(0);
    check_frame(7'h7F, 7'h7F, 7'h7F);

    // Last load wins
    run_until(3);
    do_load(4'd4, 4'd4, 4'd4);
    check("lw_ready_a", 32'(bus.ready), 32'd0);
    run_until(15);
    do_load(4'd7, 4'd7, 4'd7);
    check("lw_ready_b", 32'(bus.ready), 32'd0);
    run_until(20);
    check("lw_ready_c", 32'(bus.ready), 32'd0);
    run_until(0);
    check("lw_ready_fb", 32'(bus.ready), 32'd1);
    check_frame(7'h78, 7'h78, 7'h78);

    // Load exactly at the frame boundary
    run_until(FR - 1);
    do_load(4'd5, 4'd5, 4'd5);
    check("fb_ready", 32'(bus.ready), 32'd1);
    check_frame(7'h12, 7'h12, 7'h12);

    // Reset while a load is pending
    run_until(4);
    do_load(4'd6, 4'd6, 4'd6);
    tick();
    tick();
    check("pre_rst_ready", 32'(bus.ready), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_seg", 32'(bus.seg), 32'h7F);
    check("arst_an", 32'(bus.an), 32'(3'b111));
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_frame", 32'(bus.frame), 32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    check_frame(7'h7F, 7'h7F, 7'h7F);
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // Blink: two visible frames, two dark frames, visible again
    run_until(FR - 1);
    do_load(4'd8, 4'd8, 4'd8);
    bus.blink_en = 1'b1;
    check_frame(7'h00, 7'h00, 7'h00);
    check_frame(7'h00, 7'h00, 7'h00);
    check_frame(7'h7F, 7'h7F, 7'h7F);
    check_frame(7'h7F, 7'h7F, 7'h7F);
    check_frame(7'h00, 7'h00, 7'h00);
    bus.blink_en = 1'b0;
    check_frame(7'h00, 7'h00, 7'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
